pwm_ctrl_regs: RTL and testbench



---
 rtl/pwm_ctrl_pkg.sv | 45 ++++
 rtl/pwm_ctrl_regs_if.sv | 37 +++
 rtl/pwm_load_sequencer.sv | 114 +++++++++++
 rtl/pwm_ctrl_regs.sv | 139 +++++++++++++
 tb/tb_pwm_ctrl_regs.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_ctrl_pkg.sv
// ============================================================================
// Module  : pwm_ctrl_pkg
// Brief   : Shared encodings and constants for the PWM control register block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SETUP = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam int DUTY_MSB   = 15;
  localparam int DUTY_LSB   = 8;
  localparam int PERIOD_MSB = 7;
  localparam int PERIOD_LSB = 0;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_PEND_BIT  = 1;
  localparam int STAT_DIRTY_LSB = 2;

  // Control registers sit directly above the shadow bank.
  localparam int COMMIT_OFFSET = 0;
  localparam int STATUS_OFFSET = 1;

  function automatic int idx_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int commit_addr(input int channels);
    return channels + COMMIT_OFFSET;
  endfunction

  function automatic int status_addr(input int channels);
    return channels + STATUS_OFFSET;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ctrl_regs_if.sv
// ============================================================================
// Module  : pwm_ctrl_regs_if
// Brief   : Processor-side register bus for the PWM control block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_ctrl_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);

  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

`default_nettype wire

// File: rtl/pwm_load_sequencer.sv
// ============================================================================
// Module  : pwm_load_sequencer
// Brief   : Commit walker: visits each channel, sets up and pulses load on
//           dirty channels only, queues one commit requested mid-pass.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_load_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2
) (
  input  wire                 sys_clk,
  input  wire                 reset,
  input  wire                 commit_i,
  input  wire  [CHANNELS-1:0] dirty_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                capture_o,
  output logic                clear_o,
  output logic                busy_o,
  output logic                pending_o,
  output logic                commit_done_o,
  output logic [CHANNELS-1:0] pwm_load_o
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(CHANNELS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             busy_q;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    capture_o     = 1'b0;
    clear_o       = 1'b0;
    commit_done_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (commit_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (dirty_i[idx_q]) begin
          state_d   = ST_SETUP;
          capture_o = 1'b1;
        end else if (idx_q == c_LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SETUP: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        clear_o = 1'b1;
        if (idx_q == c_LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        commit_done_o = 1'b1;
        idx_d         = '0;
        // A commit landing in DONE folds into the queued pass.
        if (pending_q || commit_i) begin
          pending_d = 1'b0;
          state_d   = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    if (commit_i && (state_q != ST_IDLE) && (state_q != ST_DONE)) pending_d = 1'b1;
  end

  // Decoded from registered state so reset removes a pulse immediately.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_load
    assign pwm_load_o[i] = (state_q == ST_LOAD) && (idx_q == IDX_W'(i));
  end

  assign idx_o     = idx_q;
  assign busy_o    = busy_q;
  assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/pwm_ctrl_regs.sv
// ============================================================================
// Module  : pwm_ctrl_regs
// Brief   : Shadow duty/period register bank with commit-driven, glitch-free
//           update of the downstream PWM driver channels.
// Build   : define PWM_CTRL_READBACK_EN to read shadow words back over the bus.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_ctrl_regs
  import pwm_ctrl_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  wire                             sys_clk,
  input  wire                             reset,
  pwm_ctrl_regs_if.slave                  bus,
  output logic                            busy,
  output logic                            commit_done,
  output wire  [CHANNELS*DATA_WIDTH-1:0]  pwm_data,
  output logic [CHANNELS-1:0]             pwm_load
);

  localparam int                    c_IDX_W       = idx_width(CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] c_COMMIT_ADDR = ADDR_WIDTH'(commit_addr(CHANNELS));
  localparam logic [ADDR_WIDTH-1:0] c_STATUS_ADDR = ADDR_WIDTH'(status_addr(CHANNELS));

  wire  [CHANNELS-1:0]   w_wr_ch;
  wire  [CHANNELS-1:0]   w_sel;
  wire  [CHANNELS-1:0]   w_dirty;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_capture;
  logic                  w_clear;
  logic                  w_pending;
  logic                  w_commit;
  logic                  w_wr_active;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  stale_q;

`ifdef PWM_CTRL_READBACK_EN
  logic [DATA_WIDTH-1:0] w_shadow [CHANNELS];
`endif

  assign w_commit    = bus.wr_en && (bus.addr == c_COMMIT_ADDR);
  assign w_wr_active = |(w_wr_ch & w_sel);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  dirty_q;

    assign w_wr_ch[i] = bus.wr_en && (bus.addr == ADDR_WIDTH'(i));
    assign w_sel[i]   = (w_idx == c_IDX_W'(i));

    always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
        shadow_q <= '0;
        data_q   <= '0;
        dirty_q  <= 1'b0;
      end else begin
        if (w_wr_ch[i]) begin
          shadow_q <= bus.wdata;
          dirty_q  <= 1'b1;
        end else if (w_clear && w_sel[i] && !stale_q) begin
          dirty_q <= 1'b0;
        end
        // Driver word moves on entry to SETUP and is held through LOAD.
        if (w_capture && w_sel[i]) data_q <= shadow_q;
      end
    end

    assign w_dirty[i]                              = dirty_q;
    assign pwm_data[i*DATA_WIDTH +: DATA_WIDTH]    = data_q;
`ifdef PWM_CTRL_READBACK_EN
    assign w_shadow[i]                             = shadow_q;
`endif
  end

  // Remembers a write to the active channel after its word was captured, so
  // the LOAD-time clear cannot drop an update that this pass did not apply.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      stale_q <= 1'b0;
    end else begin
      stale_q <= w_capture ? w_wr_active : (stale_q | w_wr_active);
    end
  end

  pwm_load_sequencer #(
    .CHANNELS (CHANNELS),
    .IDX_W    (c_IDX_W)
  ) u_seq (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .commit_i      (w_commit),
    .dirty_i       (w_dirty),
    .idx_o         (w_idx),
    .capture_o     (w_capture),
    .clear_o       (w_clear),
    .busy_o        (busy),
    .pending_o     (w_pending),
    .commit_done_o (commit_done),
    .pwm_load_o    (pwm_load)
  );

  always_comb begin
    w_status                             = '0;
    w_status[STAT_BUSY_BIT]              = busy;
    w_status[STAT_PEND_BIT]              = w_pending;
    w_status[STAT_DIRTY_LSB +: CHANNELS] = w_dirty;
  end

  always_comb begin
    w_rd_mux = '0;
    if (bus.addr == c_STATUS_ADDR) w_rd_mux = w_status;
`ifdef PWM_CTRL_READBACK_EN
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.addr == ADDR_WIDTH'(k)) w_rd_mux = w_shadow[k];
    end
`endif
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (bus.rd_en) begin
      rdata_q <= w_rd_mux;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_ctrl_regs.sv
// ============================================================================
// Module  : tb_pwm_ctrl_regs
// Brief   : Directed bench for pwm_ctrl_regs with a cycle-stamped scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_ctrl_regs;

  localparam int         CH       = 4;
  localparam int         DW       = 16;
  localparam int         AW       = 4;
  localparam logic [3:0] A_COMMIT = 4'd4;
  localparam logic [3:0] A_STATUS = 4'd5;

  typedef struct { int cyc; int ch; logic [15:0] data; } ev_t;
  typedef struct { int cyc; logic [3:0] addr; logic [15:0] data; } inj_t;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        busy;
  logic        commit_done;
  logic [63:0] pwm_data;
  logic [3:0]  pwm_load;

  int          checks = 0;
  int          errors = 0;
  ev_t         sb[$];
  inj_t        inj[$];
  logic [15:0] m_shadow [CH];
  int          done_cyc;
  int          done2_cyc;

  pwm_ctrl_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pwm_ctrl_regs #(.CHANNELS(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .commit_done (commit_done),
    .pwm_data    (pwm_data),
    .pwm_load    (pwm_load)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge sys_clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge sys_clk);
    bus.wr_en = 1'b0;
    if (a < 4'(CH)) m_shadow[a[1:0]] = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag);
    @(negedge sys_clk);
    bus.rd_en = 1'b1; bus.addr = a;
    @(negedge sys_clk);
    bus.rd_en = 1'b0;
    chk(tag, bus.rdata, exp);
  endtask

  // Expected events of one pass: clean channel 1 cycle, dirty channel 3 cycles.
  task automatic sched(input int base, input logic [3:0] d, output int done);
    int c;
    c = base + 1;
    for (int ch = 0; ch < CH; ch++) begin
      if (d[ch]) begin
        sb.push_back('{c + 2, ch, m_shadow[ch]});
        c += 3;
      end else begin
        c += 1;
      end
    end
    sb.push_back('{c, -1, 16'h0});
    done = c;
  endtask

  // Called at the negedge of cycle 1 (COMMIT sampled at edge 0).
  task automatic observe(input int last);
    logic [63:0] prev;
    ev_t         ev;
    prev = pwm_data;
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      if (cyc > 1) @(negedge sys_clk);
      bus.wr_en = 1'b0;
      chk("busy", busy, (cyc <= last));
      chk("load_onehot", $onehot0(pwm_load), 1);
      for (int ch = 0; ch < CH; ch++) begin
        if (pwm_load[ch]) begin
          chk("load_expected", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            ev = sb.pop_front();
            chk("load_cycle", cyc, ev.cyc);
            chk("load_ch", ch, ev.ch);
            chk("load_data", pwm_data[ch*16 +: 16], ev.data);
            chk("data_before_load", prev[ch*16 +: 16], ev.data);
          end
        end
      end
      if (commit_done) begin
        chk("done_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ev = sb.pop_front();
          chk("done_cycle", cyc, ev.cyc);
        end
      end
      prev = pwm_data;
      if (inj.size() > 0 && inj[0].cyc == cyc) begin
        bus.addr  = inj[0].addr;
        bus.wdata = inj[0].data;
        bus.wr_en = 1'b1;
        void'(inj.pop_front());
      end
    end
    bus.wr_en = 1'b0;
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < CH; i++) m_shadow[i] = 16'h0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;

    // Reset state
    chk("rst_load", pwm_load, 0);
    chk("rst_data", pwm_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", commit_done, 0);
    rd(A_STATUS, 16'h0, "status_after_reset");
    rd(4'd0, 16'h0, "ch0_after_reset");
    wr(4'd15, 16'hFFFF);
    rd(4'd15, 16'h0, "unmapped_read");

    // Two dirty channels
    wr(4'd1, 16'h8040);
    wr(4'd3, 16'h20FF);
    rd(A_STATUS, 16'h0028, "status_dirty_1_3");
    wr(A_COMMIT, 16'h0);
    sched(0, 4'b1010, done_cyc);
    observe(done_cyc);
    chk("data_after_pass", pwm_data, {16'h20FF, 16'h0000, 16'h8040, 16'h0000});
    rd(A_STATUS, 16'h0, "status_clean");

    // Nothing dirty
    wr(A_COMMIT, 16'h0);
    sched(0, 4'b0000, done_cyc);
    chk("empty_done_at_5", done_cyc, 5);
    observe(done_cyc);

    // ch0 written after its scan, COMMIT while busy -> queued second pass
    wr(4'd1, 16'h1234);
    wr(A_COMMIT, 16'h0);
    sched(0, 4'b0010, done_cyc);
    inj.push_back('{3, 4'd0, 16'h0ABC});
    inj.push_back('{5, A_COMMIT, 16'h0});
    m_shadow[0] = 16'h0ABC;
    sched(done_cyc, 4'b0001, done2_cyc);
    observe(done2_cyc);
    rd(A_STATUS, 16'h0, "status_after_pending");

    // Write to ch2 on the edge of its LOAD
    wr(4'd2, 16'h5555);
    wr(A_COMMIT, 16'h0);
    sched(0, 4'b0100, done_cyc);
    inj.push_back('{5, 4'd2, 16'h6666});
    observe(done_cyc);
    m_shadow[2] = 16'h6666;
    rd(A_STATUS, 16'h0010, "status_ch2_still_dirty");
    wr(A_COMMIT, 16'h0);
    sched(0, 4'b0100, done_cyc);
    observe(done_cyc);
    rd(A_STATUS, 16'h0, "status_ch2_applied");

    // Reset asserted during LOAD of ch0
    wr(4'd0, 16'h1111);
    wr(4'd1, 16'h2222);
    wr(4'd2, 16'h3333);
    wr(4'd3, 16'h4444);
    wr(A_COMMIT, 16'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("midpass_load", pwm_load, 4'b0001);
    chk("midpass_data", pwm_data[15:0], 16'h1111);
    #1 reset = 1'b1;
    #1;
    chk("async_load_drop", pwm_load, 0);
    chk("async_busy", busy, 0);
    chk("async_data", pwm_data, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    rd(A_STATUS, 16'h0, "status_after_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
